// File: rtl/rgb_pwm_pkg.sv
// Shared definitions for the RGB LED PWM controller: register map, store-size
// encodings, CTRL/STATUS bit positions and the store lane helpers.
package rgb_pwm_pkg;

  localparam int unsigned DutyW = 8;

  // Word offsets inside the 16-byte register window (address bits [3:2]).
  typedef enum logic [1:0] {
    RegCtrl     = 2'd0,
    RegPrescale = 2'd1,
    RegDuty     = 2'd2,
    RegStatus   = 2'd3
  } reg_e;

  // funct3 access sizes on the store path.
  typedef enum logic [2:0] {
    SizeByte = 3'b000,
    SizeHalf = 3'b001,
    SizeWord = 3'b010
  } size_e;

  localparam int unsigned CtrlEnableBit   = 0;
  localparam int unsigned StatusCntLsb    = 0;
  localparam int unsigned StatusEnableBit = 8;
  localparam int unsigned StatusBusyBit   = 9;
  localparam int unsigned StatusPeriodLsb = 16;

  // Byte enables for a store; all-zero means the store is dropped
  // (misaligned half/word or an unsupported size).
  function automatic logic [3:0] store_strobe(input logic [2:0] funct3,
                                              input logic [1:0] offs);
    logic [3:0] be;
    be = 4'b0000;
    case (funct3)
      SizeByte: be = 4'b0001 << offs;
      SizeHalf: if (!offs[0]) be = offs[1] ? 4'b1100 : 4'b0011;
      SizeWord: if (offs == 2'b00) be = 4'b1111;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

  // Right-aligned store data replicated onto every lane it could target.
  function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                              input logic [31:0] data);
    logic [31:0] lanes;
    case (funct3)
      SizeByte: lanes = {4{data[7:0]}};
      SizeHalf: lanes = {2{data[15:0]}};
      default:  lanes = data;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rgb_pwm_if.sv
// Data-memory bus slice seen by the RGB PWM controller: store path plus the
// registered load path shared with RAM.
interface rgb_pwm_if;
  logic        write_mem;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [2:0]  funct3;
  logic [31:0] read_address;
  logic [31:0] read_data;

  modport master (
    output write_mem, write_address, write_data, funct3, read_address,
    input  read_data
  );

  modport slave (
    input  write_mem, write_address, write_data, funct3, read_address,
    output read_data
  );
endinterface

// File: rtl/pwm_channel.sv
// One PWM colour channel: active duty register with boundary reload (or
// one-step fade when RGB_PWM_FADE_EN is defined), compare, registered pin.
module pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             boundary,
  input  logic [DutyW-1:0] target,
  input  logic [DutyW-1:0] pwm_cnt,
  output logic             pin,
  output logic             busy
);

  localparam logic [DutyW-1:0] DutyOne = {{(DutyW-1){1'b0}}, 1'b1};

  logic [DutyW-1:0] active_q, active_d;
  logic             pin_q, pin_d;
  logic             on;

  // Active duty only moves at period boundaries so a pulse is never cut short.
  always_comb begin
    active_d = active_q;
    if (!enable) begin
      active_d = target;
    end else if (boundary) begin
`ifdef RGB_PWM_FADE_EN
      if (active_q < target) begin
        active_d = active_q + DutyOne;
      end else if (active_q > target) begin
        active_d = active_q - DutyOne;
      end
`else
      active_d = target;
`endif
    end
  end

  // Compare against the running counter; pin level is registered.
  always_comb begin
    on    = enable && (pwm_cnt < active_q);
    pin_d = on ^ ACTIVE_LOW;
  end

  // Duty and pin state; reset parks the pin at its off level at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= '0;
      pin_q    <= ACTIVE_LOW;
    end else begin
      active_q <= active_d;
      pin_q    <= pin_d;
    end
  end

  assign pin = pin_q;

`ifdef RGB_PWM_FADE_EN
  assign busy = (active_q != target);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: rtl/rgb_pwm.sv
// Memory-mapped RGB LED PWM controller on the data-memory bus. Holds bus
// decode, CTRL/PRESCALE/DUTY registers, prescaler, PWM counter and period
// count; three pwm_channel instances drive the pins.
// Optional macro RGB_PWM_FADE_EN turns DUTY into a fade target.
module rgb_pwm
  import rgb_pwm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic     clk,
  input  logic     reset_n,
  rgb_pwm_if.slave bus,
  output logic     red,
  output logic     green,
  output logic     blue
);

  // Store decode
  logic        wr_in_win;
  logic        wr_en;
  logic        presc_store;
  logic [3:0]  wr_be;
  logic [31:0] wr_lanes;
  reg_e        wr_reg;

  assign wr_in_win   = (bus.write_address[31:4] == BASE_ADDR[31:4]);
  assign wr_be       = store_strobe(bus.funct3, bus.write_address[1:0]);
  assign wr_lanes    = store_lanes(bus.funct3, bus.write_data);
  assign wr_reg      = reg_e'(bus.write_address[3:2]);
  assign wr_en       = bus.write_mem && wr_in_win && (wr_be != 4'b0000);
  assign presc_store = wr_en && (wr_reg == RegPrescale);

  // Registers
  logic        enable_q, enable_d;
  logic [15:0] prescale_q, prescale_d;
  logic [23:0] duty_q, duty_d;
  logic [15:0] prescale_merged;
  logic [23:0] duty_merged;
  logic [15:0] unused_presc_hi;
  logic [7:0]  unused_duty_hi;

  // Lanes above the implemented register width are simply dropped.
  assign {unused_presc_hi, prescale_merged} =
      merge_bytes({16'h0000, prescale_q}, wr_lanes, wr_be);
  assign {unused_duty_hi, duty_merged} = merge_bytes({8'h00, duty_q}, wr_lanes, wr_be);

  // Register writes from accepted stores.
  always_comb begin
    enable_d   = enable_q;
    prescale_d = prescale_q;
    duty_d     = duty_q;
    if (wr_en) begin
      unique case (wr_reg)
        RegCtrl:     if (wr_be[0]) enable_d = wr_lanes[CtrlEnableBit];
        RegPrescale: prescale_d = prescale_merged;
        RegDuty:     duty_d = duty_merged;
        RegStatus:   ;
        default:     ;
      endcase
    end
  end

  // Counters
  logic [15:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [15:0] period_q, period_d;
  logic        tick;
  logic        boundary;

  assign tick     = enable_q && (presc_cnt_q == prescale_q);
  assign boundary = tick && (pwm_cnt_q == 8'hFF);

  // Prescaler, PWM counter and period count; disabled holds both counters at
  // zero so re-enabling always starts a fresh period.
  always_comb begin
    presc_cnt_d = presc_cnt_q + 16'd1;
    pwm_cnt_d   = pwm_cnt_q;
    period_d    = period_q;
    if (!enable_q) begin
      presc_cnt_d = '0;
      pwm_cnt_d   = '0;
    end else begin
      if (tick || presc_store) presc_cnt_d = '0;
      if (tick) pwm_cnt_d = pwm_cnt_q + 8'd1;
      if (boundary) period_d = period_q + 16'd1;
    end
  end

  // Channels
  logic busy_r, busy_g, busy_b;

  pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_red (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable_q),
    .boundary (boundary),
    .target   (duty_q[7:0]),
    .pwm_cnt  (pwm_cnt_q),
    .pin      (red),
    .busy     (busy_r)
  );

  pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_green (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable_q),
    .boundary (boundary),
    .target   (duty_q[15:8]),
    .pwm_cnt  (pwm_cnt_q),
    .pin      (green),
    .busy     (busy_g)
  );

  pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_blue (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable_q),
    .boundary (boundary),
    .target   (duty_q[23:16]),
    .pwm_cnt  (pwm_cnt_q),
    .pin      (blue),
    .busy     (busy_b)
  );

  // Load path
  logic        rd_in_win;
  logic [31:0] status_word;
  logic [31:0] read_data_q, read_data_d;
  logic [1:0]  unused_rd_lsb;

  assign rd_in_win     = (bus.read_address[31:4] == BASE_ADDR[31:4]);
  assign unused_rd_lsb = bus.read_address[1:0];

  // Register read mux; anything outside the window reads zero.
  always_comb begin
    status_word = '0;
    status_word[StatusCntLsb +: 8]     = pwm_cnt_q;
    status_word[StatusEnableBit]       = enable_q;
    status_word[StatusBusyBit]         = busy_r | busy_g | busy_b;
    status_word[StatusPeriodLsb +: 16] = period_q;

    read_data_d = '0;
    if (rd_in_win) begin
      unique case (reg_e'(bus.read_address[3:2]))
        RegCtrl:     read_data_d = {31'b0, enable_q};
        RegPrescale: read_data_d = {16'b0, prescale_q};
        RegDuty:     read_data_d = {8'b0, duty_q};
        RegStatus:   read_data_d = status_word;
        default:     read_data_d = '0;
      endcase
    end
  end

  // All architectural state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q    <= 1'b0;
      prescale_q  <= '0;
      duty_q      <= '0;
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      period_q    <= '0;
      read_data_q <= '0;
    end else begin
      enable_q    <= enable_d;
      prescale_q  <= prescale_d;
      duty_q      <= duty_d;
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      period_q    <= period_d;
      read_data_q <= read_data_d;
    end
  end

  assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_rgb_pwm.sv
// Self-checking bench for rgb_pwm. Load results go through an expected-value
// queue; pin behaviour is checked by counting low cycles over known windows.
module tb_rgb_pwm;

  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam logic [2:0]  F3B  = 3'b000;
  localparam logic [2:0]  F3H  = 3'b001;
  localparam logic [2:0]  F3W  = 3'b010;

`ifdef RGB_PWM_FADE_EN
  localparam int   GlitchNewLow = 63;
  localparam logic GlitchBusy   = 1'b1;
`else
  localparam int   GlitchNewLow = 16;
  localparam logic GlitchBusy   = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic red, green, blue;

  rgb_pwm_if bus ();

  rgb_pwm #(
    .BASE_ADDR  (BASE),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .red     (red),
    .green   (green),
    .blue    (blue)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [31:0] ra;
    logic [31:0] exp;
  } step_t;

  task automatic bus_idle();
    bus.write_mem     = 1'b0;
    bus.write_address = '0;
    bus.write_data    = '0;
    bus.funct3        = F3W;
    bus.read_address  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus_idle();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data,
                       input logic [2:0] f3);
    @(negedge clk);
    bus.write_mem     = 1'b1;
    bus.write_address = addr;
    bus.write_data    = data;
    bus.funct3        = f3;
    @(negedge clk);
    bus.write_mem = 1'b0;
  endtask

  task automatic issue_load(input logic [31:0] addr, input logic [31:0] exp);
    bus.read_address = addr;
    exp_q.push_back(exp);
  endtask

  task automatic test_reset();
    step_t tbl[$];
    logic [31:0] e;
    bus_idle();
    reset_n = 1'b0;
    bus.read_address = BASE + 32'hC;
    repeat (2) @(negedge clk);
    checks++;
    if ({red, green, blue} !== 3'b111) begin
      errors++;
      $display("FAIL reset_pins: rgb=%b expected=111", {red, green, blue});
    end
    checks++;
    if (bus.read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_read: read_data=%h expected=00000000", bus.read_data);
    end
    reset_n = 1'b1;
    issue_load(BASE + 32'hC, 32'h0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.read_data !== e) begin
      errors++;
      $display("FAIL status_after_reset: read_data=%h expected=%h", bus.read_data, e);
    end
    tbl.push_back('{"ctrl_mask", BASE + 32'h0, 32'hFFFF_FFFE, F3W, BASE + 32'h0, 32'h0});
    tbl.push_back('{"presc_upper", BASE + 32'h4, 32'hABCD_1234, F3W, BASE + 32'h4,
                    32'h0000_1234});
    tbl.push_back('{"presc_missw", BASE + 32'h6, 32'h0, F3W, BASE + 32'h4, 32'h0000_1234});
    tbl.push_back('{"status_ro", BASE + 32'hC, 32'hFFFF_FFFF, F3W, BASE + 32'hC, 32'h0});
    tbl.push_back('{"out_window", BASE + 32'h10, 32'hFFFF_FFFF, F3W, BASE + 32'h10, 32'h0});
    foreach (tbl[i]) begin
      store(tbl[i].wa, tbl[i].wd, tbl[i].f3);
      issue_load(tbl[i].ra, tbl[i].exp);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bus.read_data !== e) begin
        errors++;
        $display("FAIL %s: read_data=%h expected=%h", tbl[i].name, bus.read_data, e);
      end
    end
  endtask

  task automatic test_byte_lanes();
    step_t tbl[$];
    logic [31:0] e;
    do_reset();
    tbl.push_back('{"duty_clear", BASE + 32'h8, 32'h0, F3W, BASE + 32'h8, 32'h0});
    tbl.push_back('{"sb_lane1", BASE + 32'h9, 32'hABCD_EF40, F3B, BASE + 32'h8,
                    32'h0000_4000});
    tbl.push_back('{"sh_misaligned", BASE + 32'h9, 32'h0000_FFFF, F3H, BASE + 32'h8,
                    32'h0000_4000});
    tbl.push_back('{"sh_upper", BASE + 32'hA, 32'h0000_1234, F3H, BASE + 32'h8,
                    32'h0034_4000});
    tbl.push_back('{"sb_lane0", BASE + 32'h8, 32'h0000_0077, F3B, BASE + 32'h8,
                    32'h0034_4077});
    tbl.push_back('{"sw_misaligned", BASE + 32'hB, 32'hFFFF_FFFF, F3W, BASE + 32'h8,
                    32'h0034_4077});
    tbl.push_back('{"bad_size", BASE + 32'h8, 32'hFFFF_FFFF, 3'b011, BASE + 32'h8,
                    32'h0034_4077});
    tbl.push_back('{"sw_duty_all", BASE + 32'h8, 32'hFFFF_FFFF, F3W, BASE + 32'h8,
                    32'h00FF_FFFF});
    tbl.push_back('{"sh_presc_lo", BASE + 32'h4, 32'h0000_BEEF, F3H, BASE + 32'h4,
                    32'h0000_BEEF});
    tbl.push_back('{"sh_presc_hi", BASE + 32'h6, 32'h0000_1111, F3H, BASE + 32'h4,
                    32'h0000_BEEF});
    tbl.push_back('{"sb_ctrl_b1", BASE + 32'h1, 32'h0000_00FF, F3B, BASE + 32'h0, 32'h0});
    foreach (tbl[i]) begin
      store(tbl[i].wa, tbl[i].wd, tbl[i].f3);
      issue_load(tbl[i].ra, tbl[i].exp);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bus.read_data !== e) begin
        errors++;
        $display("FAIL %s: read_data=%h expected=%h", tbl[i].name, bus.read_data, e);
      end
    end
  endtask

  task automatic test_basic_pwm();
    int r_low = 0;
    int g_low = 0;
    int b_low = 0;
    do_reset();
    store(BASE + 32'h8, 32'h0080_FF00, F3W);
    store(BASE + 32'h4, 32'h0, F3W);
    store(BASE + 32'h0, 32'h1, F3W);
    bus.read_address = BASE + 32'hC;
    repeat (4) @(negedge clk);
    for (int m = 0; m < 256; m++) begin
      @(negedge clk);
      if (red === 1'b0) r_low++;
      if (green === 1'b0) g_low++;
      if (blue === 1'b0) b_low++;
    end
    checks++;
    if (r_low != 0) begin
      errors++;
      $display("FAIL basic_red: low_cycles=%0d expected=0", r_low);
    end
    checks++;
    if (g_low != 255) begin
      errors++;
      $display("FAIL basic_green: low_cycles=%0d expected=255", g_low);
    end
    checks++;
    if (b_low != 128) begin
      errors++;
      $display("FAIL basic_blue: low_cycles=%0d expected=128", b_low);
    end
    // Asynchronous reset between clock edges must force pins off at once.
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({red, green, blue} !== 3'b111 || bus.read_data !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: rgb=%b read_data=%h expected=111/00000000",
               {red, green, blue}, bus.read_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_glitch_free();
    int low0 = 0;
    int low1 = 0;
    logic [31:0] e;
    do_reset();
    store(BASE + 32'h8, 32'h0000_0040, F3W);
    store(BASE + 32'h0, 32'h1, F3W);
    for (int m = 0; m < 512; m++) begin
      @(negedge clk);
      if (red === 1'b0) begin
        if (m < 256) low0++;
        else low1++;
      end
      bus.write_mem = 1'b0;
      if (m == 'h81 || m == 'h181) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.read_data !== e) begin
          errors++;
          $display("FAIL glitch_status_%0d: read_data=%h expected=%h", m, bus.read_data, e);
        end
      end
      if (m == 'h1F) begin
        bus.write_mem     = 1'b1;
        bus.write_address = BASE + 32'h8;
        bus.write_data    = 32'h0000_0010;
        bus.funct3        = F3W;
      end
      if (m == 'h80 || m == 'h180) begin
        issue_load(BASE + 32'hC, {(m < 256) ? 16'd0 : 16'd1, 6'b0, GlitchBusy, 1'b1, 8'h81});
      end
    end
    checks++;
    if (low0 != 64) begin
      errors++;
      $display("FAIL glitch_old_period: low_cycles=%0d expected=64", low0);
    end
    checks++;
    if (low1 != GlitchNewLow) begin
      errors++;
      $display("FAIL glitch_new_period: low_cycles=%0d expected=%0d", low1, GlitchNewLow);
    end
  endtask

  task automatic test_prescale_disable();
    int r_low = 0;
    logic [31:0] e;
    do_reset();
    store(BASE + 32'h8, 32'h00FF_0080, F3W);
    store(BASE + 32'h4, 32'h3, F3W);
    store(BASE + 32'h0, 32'h1, F3W);
    for (int m = 0; m <= 1024; m++) begin
      @(negedge clk);
      if (m < 1024 && red === 1'b0) r_low++;
      if (m == 1022 || m == 1024) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.read_data !== e) begin
          errors++;
          $display("FAIL presc_status_%0d: read_data=%h expected=%h", m, bus.read_data, e);
        end
      end
      if (m == 1021) issue_load(BASE + 32'hC, 32'h0000_01FF);
      if (m == 1023) issue_load(BASE + 32'hC, 32'h0001_0100);
    end
    checks++;
    if (r_low != 512) begin
      errors++;
      $display("FAIL presc_red_low: low_cycles=%0d expected=512", r_low);
    end
    store(BASE + 32'h0, 32'h0, F3W);
    issue_load(BASE + 32'hC, 32'h0001_0000);
    @(negedge clk);
    checks++;
    if ({red, green, blue} !== 3'b111) begin
      errors++;
      $display("FAIL disable_pins: rgb=%b expected=111", {red, green, blue});
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.read_data !== e) begin
      errors++;
      $display("FAIL disable_status: read_data=%h expected=%h", bus.read_data, e);
    end
  endtask

  task automatic test_back_to_back();
    step_t tbl[$];
    logic [31:0] e;
    logic pending = 1'b0;
    do_reset();
    // wa==0 means no store this cycle, ra==0 means no load.
    tbl.push_back('{"b2b_w_duty", BASE + 32'h8, 32'h0012_3456, F3W, 32'h0, 32'h0});
    tbl.push_back('{"b2b_r_duty", BASE + 32'h4, 32'h0000_0007, F3B, BASE + 32'h8,
                    32'h0012_3456});
    tbl.push_back('{"b2b_r_presc_old", BASE + 32'h5, 32'h0000_0001, F3B, BASE + 32'h4,
                    32'h0000_0007});
    tbl.push_back('{"b2b_r_presc_new", 32'h0, 32'h0, F3W, BASE + 32'h4, 32'h0000_0107});
    tbl.push_back('{"b2b_r_ctrl", 32'h0, 32'h0, F3W, BASE + 32'h0, 32'h0});
    tbl.push_back('{"b2b_r_outside", 32'h0, 32'h0, F3W, 32'h0000_3008, 32'h0});
    tbl.push_back('{"b2b_drain", 32'h0, 32'h0, F3W, 32'h0, 32'h0});
    foreach (tbl[i]) begin
      @(negedge clk);
      if (pending) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.read_data !== e) begin
          errors++;
          $display("FAIL %s: read_data=%h expected=%h", tbl[i - 1].name, bus.read_data, e);
        end
      end
      bus.write_mem     = (tbl[i].wa != 32'h0);
      bus.write_address = tbl[i].wa;
      bus.write_data    = tbl[i].wd;
      bus.funct3        = tbl[i].f3;
      pending = (tbl[i].ra != 32'h0);
      if (pending) issue_load(tbl[i].ra, tbl[i].exp);
    end
    bus.write_mem = 1'b0;
  endtask

`ifdef RGB_PWM_FADE_EN
  task automatic test_fade();
    int low[5];
    logic [31:0] e;
    foreach (low[k]) low[k] = 0;
    do_reset();
    store(BASE + 32'h0, 32'h1, F3W);
    for (int m = 0; m < 1280; m++) begin
      @(negedge clk);
      if (red === 1'b0) low[m / 256]++;
      bus.write_mem = 1'b0;
      if (m == 11 || m == 1001 || m == 1101) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.read_data !== e) begin
          errors++;
          $display("FAIL fade_status_%0d: read_data=%h expected=%h", m, bus.read_data, e);
        end
      end
      if (m == 0) begin
        bus.write_mem     = 1'b1;
        bus.write_address = BASE + 32'h8;
        bus.write_data    = 32'h0000_0004;
        bus.funct3        = F3W;
      end
      if (m == 10) issue_load(BASE + 32'hC, 32'h0000_030B);
      if (m == 1000) issue_load(BASE + 32'hC, 32'h0003_03E9);
      if (m == 1100) issue_load(BASE + 32'hC, 32'h0004_014D);
    end
    foreach (low[k]) begin
      checks++;
      if (low[k] != k) begin
        errors++;
        $display("FAIL fade_period_%0d: low_cycles=%0d expected=%0d", k, low[k], k);
      end
    end
  endtask
`endif

  initial begin
    bus_idle();
    test_reset();
    test_byte_lanes();
    test_basic_pwm();
    test_glitch_free();
    test_prescale_disable();
    test_back_to_back();
`ifdef RGB_PWM_FADE_EN
    test_fade();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit after %0d checks", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
